dbus_sram_resp: RTL and testbench

Responder end of the core's AHB-lite-like data bus: accepts pipelined address/data-phase transfers from the bus initiator and turns them into accesses on a single-port synchronous SRAM. Decodes one address window, applies byte lanes, inserts configurable wait states and a read-after-write stall, and reports faults through `hresp`. Sits between the core bus interface and the data SRAM macro.

---
 rtl/dbus_sram_resp.sv | 148 ++++++++++++++
 tb/tb_dbus_sram_resp.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_sram_resp.sv
// Data-bus responder: pipelined address/data-phase transfers onto a single-port synchronous SRAM.
// Optional feature: define DBUS_SRAM_EXEC_EN to let hprot=0 (instruction) reads hit the SRAM.
module dbus_sram_resp #(
  parameter logic [31:0] BASE        = 32'h2000_0000,
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   haddr,
  input  logic          hprot,
  input  logic [1:0]    hsize,
  input  logic          hwrite,
  input  logic [31:0]   hwdata,
  input  logic          htrans,
  output logic [31:0]   hrdata,
  output logic          hresp,
  output logic          hready,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, DATA, STALL} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          fault_q, write_q;
  logic [3:0]    lanes_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   rdata_q;

  logic          in_window, size_bad, prot_bad, ap_fault;
  logic [3:0]    ap_lanes;
  logic          first, done, commit, raw, accept;

  assign in_window = (haddr[31:AW+2] == BASE[31:AW+2]);
  assign size_bad  = (hsize == 2'd3) ||
                     ((hsize == 2'd1) && haddr[0]) ||
                     ((hsize == 2'd2) && (haddr[1:0] != 2'b00));
`ifdef DBUS_SRAM_EXEC_EN
  assign prot_bad  = ~hprot & hwrite;
`else
  assign prot_bad  = ~hprot;
`endif
  assign ap_fault  = ~in_window | size_bad | prot_bad;

  always_comb begin
    case (hsize)
      2'd0:    ap_lanes = 4'b0001 << haddr[1:0];
      2'd1:    ap_lanes = 4'b0011 << haddr[1:0];
      default: ap_lanes = 4'b1111;
    endcase
  end

  // A write commits in its first data-phase cycle; a read issued in that same
  // cycle would collide on the single SRAM port, so the read is held off once.
  assign first  = (state_q == DATA) && (cnt_q == 4'd0);
  assign done   = (state_q == DATA) && (fault_q || (cnt_q == WAIT_LAST));
  assign commit = first && !fault_q && write_q;
  assign raw    = commit && done && htrans && !hwrite && !ap_fault;
  assign hready = (state_q != DATA) || (done && !raw);
  assign accept = rstn && htrans && hready;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (commit) begin
      mem_en    = 1'b1;
      mem_we    = lanes_q;
      mem_addr  = addr_q;
      mem_wdata = hwdata;
    end else if (accept && !hwrite && !ap_fault) begin
      mem_en   = 1'b1;
      mem_addr = haddr[AW+1:2];
    end
  end

  always_comb begin
    hresp  = done && fault_q;
    hrdata = rdata_q;
    if (done && fault_q) begin
      hrdata = 32'h0;
    end else if (first && !write_q && !fault_q) begin
      hrdata = mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DATA;
          cnt_d   = 4'd0;
        end
      end
      DATA: begin
        if (!done) begin
          cnt_d = cnt_q + 4'd1;
        end else if (raw) begin
          state_d = STALL;
        end else if (accept) begin
          cnt_d = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      STALL: begin
        cnt_d   = 4'd0;
        state_d = accept ? DATA : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      fault_q <= 1'b0;
      write_q <= 1'b0;
      lanes_q <= 4'b0000;
      addr_q  <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        fault_q <= ap_fault;
        write_q <= hwrite;
        lanes_q <= ap_lanes;
        addr_q  <= haddr[AW+1:2];
      end
      if (first && !write_q && !fault_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_resp.sv
// Directed bench for dbus_sram_resp: a zero-wait instance driven from a vector table
// and a two-wait instance exercised with hand-written multi-cycle sequences.
module tb_dbus_sram_resp;

  localparam logic [31:0] B = 32'h2000_0000;
`ifdef DBUS_SRAM_EXEC_EN
  localparam bit EXEC = 1'b1;
`else
  localparam bit EXEC = 1'b0;
`endif

  typedef struct {
    logic        tr;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        wr;
    logic        prot;
    logic [31:0] wd;
    logic        rdy;
    logic        resp;
    logic [31:0] rd;
    logic        en;
    logic [3:0]  we;
    logic [9:0]  ma;
    logic [31:0] mwd;
  } vec_t;

  logic clk, rstn, rstn2;
  int   n_vec, n_err;

  // zero-wait instance
  logic [31:0] haddr, hwdata, hrdata, mem_wdata, mem_rdata;
  logic [1:0]  hsize;
  logic        hprot, hwrite, htrans, hresp, hready, mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem0 [0:1023];

  // two-wait instance
  logic [31:0] haddr2, hwdata2, hrdata2, mem_wdata2, mem_rdata2;
  logic [1:0]  hsize2;
  logic        hprot2, hwrite2, htrans2, hresp2, hready2, mem_en2;
  logic [3:0]  mem_we2;
  logic [9:0]  mem_addr2;
  logic [31:0] mem2 [0:1023];

  dbus_sram_resp #(.BASE(B), .AW(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn), .haddr(haddr), .hprot(hprot), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata), .htrans(htrans), .hrdata(hrdata),
    .hresp(hresp), .hready(hready), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dbus_sram_resp #(.BASE(B), .AW(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rstn(rstn2), .haddr(haddr2), .hprot(hprot2), .hsize(hsize2),
    .hwrite(hwrite2), .hwdata(hwdata2), .htrans(htrans2), .hrdata(hrdata2),
    .hresp(hresp2), .hready(hready2), .mem_en(mem_en2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous SRAM models, preloaded while their responder is in reset.
  always @(posedge clk) begin
    if (!rstn) begin
      mem0[0]   <= 32'hDEAD_BEEF;
      mem0[1]   <= 32'h1122_3344;
      mem0[2]   <= 32'h0;
      mem0[3]   <= 32'h0;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      mem_rdata <= mem0[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem0[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (!rstn2) begin
      mem2[0]    <= 32'hDEAD_BEEF;
      mem2[1]    <= 32'h1122_3344;
      mem_rdata2 <= 32'h0;
    end else if (mem_en2) begin
      mem_rdata2 <= mem2[mem_addr2];
      for (int b = 0; b < 4; b++)
        if (mem_we2[b]) mem2[mem_addr2][8*b +: 8] <= mem_wdata2[8*b +: 8];
    end
  end

  function automatic vec_t mk(input logic tr, input logic [31:0] a, input logic [1:0] sz,
                              input logic wr, input logic pr, input logic [31:0] wd,
                              input logic rdy, input logic resp, input logic [31:0] rd,
                              input logic en, input logic [3:0] we, input logic [9:0] ma,
                              input logic [31:0] mwd);
    vec_t v;
    v.tr = tr; v.addr = a; v.sz = sz; v.wr = wr; v.prot = pr; v.wd = wd;
    v.rdy = rdy; v.resp = resp; v.rd = rd; v.en = en; v.we = we; v.ma = ma; v.mwd = mwd;
    return v;
  endfunction

  task automatic cmp_vec(input int idx, input vec_t v);
    n_vec++;
    if (hready !== v.rdy || hresp !== v.resp || hrdata !== v.rd || mem_en !== v.en ||
        mem_we !== v.we || mem_addr !== v.ma || mem_wdata !== v.mwd) begin
      n_err++;
      $display("FAIL vec[%0d]: got rdy=%b resp=%b rdata=%h en=%b we=%b maddr=%0d mwdata=%h | want rdy=%b resp=%b rdata=%h en=%b we=%b maddr=%0d mwdata=%h",
               idx, hready, hresp, hrdata, mem_en, mem_we, mem_addr, mem_wdata,
               v.rdy, v.resp, v.rd, v.en, v.we, v.ma, v.mwd);
    end else begin
      $display("vec[%0d] ok: rdy=%b resp=%b rdata=%h en=%b we=%b maddr=%0d",
               idx, hready, hresp, hrdata, mem_en, mem_we, mem_addr);
    end
  endtask

  task automatic chk2(input string nm, input logic rdy, input logic resp, input logic [31:0] rd,
                      input logic en, input logic [9:0] ma);
    n_vec++;
    if (hready2 !== rdy || hresp2 !== resp || hrdata2 !== rd || mem_en2 !== en || mem_addr2 !== ma) begin
      n_err++;
      $display("FAIL %s: got rdy=%b resp=%b rdata=%h en=%b maddr=%0d | want rdy=%b resp=%b rdata=%h en=%b maddr=%0d",
               nm, hready2, hresp2, hrdata2, mem_en2, mem_addr2, rdy, resp, rd, en, ma);
    end else begin
      $display("%s ok: rdy=%b resp=%b rdata=%h en=%b maddr=%0d",
               nm, hready2, hresp2, hrdata2, mem_en2, mem_addr2);
    end
  endtask

  task automatic drv2(input logic tr, input logic [31:0] a, input logic [1:0] sz);
    @(posedge clk);
    #1;
    htrans2 = tr; haddr2 = a; hsize2 = sz; hwrite2 = 1'b0; hprot2 = 1'b1;
    @(negedge clk);
  endtask

  vec_t tbl [32];

  initial begin
    n_vec = 0; n_err = 0;
    rstn = 1'b0; rstn2 = 1'b0;
    htrans = 1'b0; haddr = 32'h0; hsize = 2'd0; hwrite = 1'b0; hprot = 1'b1; hwdata = 32'h0;
    htrans2 = 1'b0; haddr2 = 32'h0; hsize2 = 2'd0; hwrite2 = 1'b0; hprot2 = 1'b1; hwdata2 = 32'h0;

    //            tr addr      sz wr pr wdata           rdy resp rdata            en we    ma mwdata
    tbl[0]  = mk(0, B,        2, 0, 1, 32'h0,          1, 0, 32'h0,           0, 4'h0, 0, 32'h0);
    tbl[1]  = mk(1, B,        2, 0, 1, 32'h0,          1, 0, 32'h0,           1, 4'h0, 0, 32'h0);
    tbl[2]  = mk(0, B,        2, 0, 1, 32'h0,          1, 0, 32'hDEAD_BEEF,   0, 4'h0, 0, 32'h0);
    tbl[3]  = mk(1, B+3,      0, 1, 1, 32'h0,          1, 0, 32'hDEAD_BEEF,   0, 4'h0, 0, 32'h0);
    tbl[4]  = mk(0, B,        2, 0, 1, 32'h5A00_0000,  1, 0, 32'hDEAD_BEEF,   1, 4'h8, 0, 32'h5A00_0000);
    tbl[5]  = mk(1, B,        2, 0, 1, 32'h0,          1, 0, 32'hDEAD_BEEF,   1, 4'h0, 0, 32'h0);
    tbl[6]  = mk(0, B,        2, 0, 1, 32'h0,          1, 0, 32'h5AAD_BEEF,   0, 4'h0, 0, 32'h0);
    tbl[7]  = mk(1, B+4,      2, 1, 1, 32'h0,          1, 0, 32'h5AAD_BEEF,   0, 4'h0, 0, 32'h0);
    tbl[8]  = mk(1, B+4,      2, 0, 1, 32'hCAFE_F00D,  0, 0, 32'h5AAD_BEEF,   1, 4'hF, 1, 32'hCAFE_F00D);
    tbl[9]  = mk(1, B+4,      2, 0, 1, 32'h0,          1, 0, 32'h5AAD_BEEF,   1, 4'h0, 1, 32'h0);
    tbl[10] = mk(0, B,        2, 0, 1, 32'h0,          1, 0, 32'hCAFE_F00D,   0, 4'h0, 0, 32'h0);
    tbl[11] = mk(1, B,        2, 0, 1, 32'h0,          1, 0, 32'hCAFE_F00D,   1, 4'h0, 0, 32'h0);
    tbl[12] = mk(1, B+4,      2, 0, 1, 32'h0,          1, 0, 32'h5AAD_BEEF,   1, 4'h0, 1, 32'h0);
    tbl[13] = mk(1, B+2,      1, 1, 1, 32'h0,          1, 0, 32'hCAFE_F00D,   0, 4'h0, 0, 32'h0);
    tbl[14] = mk(1, B+8,      2, 1, 1, 32'h1234_0000,  1, 0, 32'hCAFE_F00D,   1, 4'hC, 0, 32'h1234_0000);
    tbl[15] = mk(0, B,        2, 0, 1, 32'hA5A5_5A5A,  1, 0, 32'hCAFE_F00D,   1, 4'hF, 2, 32'hA5A5_5A5A);
    tbl[16] = mk(1, B,        2, 0, 1, 32'h0,          1, 0, 32'hCAFE_F00D,   1, 4'h0, 0, 32'h0);
    tbl[17] = mk(0, B,        2, 0, 1, 32'h0,          1, 0, 32'h1234_BEEF,   0, 4'h0, 0, 32'h0);
    tbl[18] = mk(1, B+1,      1, 0, 1, 32'h0,          1, 0, 32'h1234_BEEF,   0, 4'h0, 0, 32'h0);
    tbl[19] = mk(1, B,        3, 0, 1, 32'h0,          1, 1, 32'h0,           0, 4'h0, 0, 32'h0);
    tbl[20] = mk(1, B+4096,   2, 0, 1, 32'h0,          1, 1, 32'h0,           0, 4'h0, 0, 32'h0);
    tbl[21] = mk(0, B,        2, 0, 1, 32'h0,          1, 1, 32'h0,           0, 4'h0, 0, 32'h0);
    tbl[22] = mk(0, B,        2, 0, 1, 32'h0,          1, 0, 32'h1234_BEEF,   0, 4'h0, 0, 32'h0);
    tbl[23] = mk(1, B,        2, 1, 0, 32'h0,          1, 0, 32'h1234_BEEF,   0, 4'h0, 0, 32'h0);
    tbl[24] = mk(1, B,        2, 0, 0, 32'hFFFF_FFFF,  1, 1, 32'h0,           EXEC, 4'h0, 0, 32'h0);
    tbl[25] = mk(0, B,        2, 0, 1, 32'h0,          1, !EXEC, EXEC ? 32'h1234_BEEF : 32'h0, 0, 4'h0, 0, 32'h0);
    tbl[26] = mk(1, B,        2, 0, 1, 32'h0,          1, 0, 32'h1234_BEEF,   1, 4'h0, 0, 32'h0);
    tbl[27] = mk(1, B+12,     2, 1, 1, 32'h0,          1, 0, 32'h1234_BEEF,   0, 4'h0, 0, 32'h0);
    tbl[28] = mk(1, B,        3, 0, 1, 32'h0BAD_F00D,  1, 0, 32'h1234_BEEF,   1, 4'hF, 3, 32'h0BAD_F00D);
    tbl[29] = mk(0, B,        2, 0, 1, 32'h0,          1, 1, 32'h0,           0, 4'h0, 0, 32'h0);
    tbl[30] = mk(1, B+12,     2, 0, 1, 32'h0,          1, 0, 32'h1234_BEEF,   1, 4'h0, 3, 32'h0);
    tbl[31] = mk(0, B,        2, 0, 1, 32'h0,          1, 0, 32'h0BAD_F00D,   0, 4'h0, 0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1; rstn2 = 1'b1;
    @(negedge clk);
    chk2("w2_reset_state", 1, 0, 32'h0, 0, 0);

    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      htrans = tbl[i].tr; haddr = tbl[i].addr; hsize = tbl[i].sz;
      hwrite = tbl[i].wr; hprot = tbl[i].prot; hwdata = tbl[i].wd;
      @(negedge clk);
      cmp_vec(i, tbl[i]);
    end
    htrans = 1'b0;

    // Two wait states: held request is not accepted until the completing cycle.
    drv2(1, B, 2);    chk2("w2_rd_addr",     1, 0, 32'h0,         1, 0);
    drv2(1, B+4, 2);  chk2("w2_wait0",       0, 0, 32'hDEAD_BEEF, 0, 0);
    drv2(1, B+4, 2);  chk2("w2_wait1",       0, 0, 32'hDEAD_BEEF, 0, 0);
    drv2(1, B+4, 2);  chk2("w2_done",        1, 0, 32'hDEAD_BEEF, 1, 1);
    drv2(0, B, 2);    chk2("w2_next_wait0",  0, 0, 32'h1122_3344, 0, 0);
    drv2(0, B, 2);    chk2("w2_next_wait1",  0, 0, 32'h1122_3344, 0, 0);
    drv2(0, B, 2);    chk2("w2_next_done",   1, 0, 32'h1122_3344, 0, 0);
    drv2(1, B, 3);    chk2("w2_flt_addr",    1, 0, 32'h1122_3344, 0, 0);
    drv2(0, B, 2);    chk2("w2_flt_done",    1, 1, 32'h0,         0, 0);
    drv2(1, B, 2);    chk2("w2_rd2_addr",    1, 0, 32'h1122_3344, 1, 0);
    drv2(0, B, 2);    chk2("w2_rd2_wait0",   0, 0, 32'hDEAD_BEEF, 0, 0);

    // Reset dropped between clock edges in the middle of the wait states.
    @(posedge clk);
    #1;
    chk2("w2_rd2_wait1", 0, 0, 32'hDEAD_BEEF, 0, 0);
    #2;
    rstn2 = 1'b0;
    #1;
    chk2("w2_rst_mid", 1, 0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    rstn2 = 1'b1;
    @(negedge clk);
    chk2("w2_after_rst", 1, 0, 32'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
